// File: rtl/pixel_fb_writer.sv
// Plot-stream framebuffer writer: FIFO-buffered, clipped 160x120 plots into a
// single-port 3-bit framebuffer, with a 1-cycle scan-out read and a clear engine.
module pixel_fb_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int SCREEN_W   = 160,
    parameter int SCREEN_H   = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_x,
    input  logic [6:0]  in_y,
    input  logic [2:0]  in_colour,
    input  logic        in_plot,
    output logic        in_ready,
    input  logic        scan_req,
    input  logic [7:0]  scan_x,
    input  logic [6:0]  scan_y,
    output logic        scan_valid,
    output logic [2:0]  scan_colour,
    input  logic        clear_start,
    input  logic [2:0]  clear_colour,
    output logic        clear_busy,
    output logic        clear_done,
    output logic [14:0] pix_written,
    output logic [14:0] pix_clipped
);

    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int MEM_SIZE = SCREEN_W * SCREEN_H;
    localparam logic [7:0]       X_LIM     = 8'(SCREEN_W);
    localparam logic [6:0]       Y_LIM     = 7'(SCREEN_H);
    localparam logic [14:0]      LAST_ADDR = 15'(MEM_SIZE - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [14:0]      SAT       = 15'h7fff;

    typedef enum logic [0:0] {IDLE, CLEAR} state_t;

    state_t state, state_next;

    // y*160 + x as shift-and-add (160 = 128 + 32)
    function automatic logic [14:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
        logic [14:0] yw;
        yw = {8'd0, y};
        return (yw << 7) + (yw << 5) + {7'd0, x};
    endfunction

    logic [17:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic [17:0]       head;

    logic [2:0]        fb_mem [MEM_SIZE];
    logic              mem_we;
    logic [14:0]       mem_waddr;
    logic [2:0]        mem_wdata;

    logic [14:0]       clear_addr;
    logic [2:0]        clear_col;

    logic scan_hit, plot_ok, accept, flush, push, clip, pop, clear_wr, clear_last;

    // Handshake: a plot transfers on any edge where in_plot && in_ready; in_ready
    // depends only on registered state, so it is stable for the whole cycle.
    assign in_ready   = (fifo_count < FULL_CNT) && (state == IDLE);
    assign clear_busy = (state == CLEAR);

    assign scan_hit   = scan_req && (scan_x < X_LIM) && (scan_y < Y_LIM);
    assign plot_ok    = (in_x < X_LIM) && (in_y < Y_LIM);
    assign accept     = in_plot && in_ready;
    assign flush      = (state == IDLE) && clear_start;
    assign push       = accept && plot_ok && !flush;
    assign clip       = accept && !plot_ok;
    assign pop        = (state == IDLE) && !flush && (fifo_count != '0) && !scan_hit;
    assign clear_wr   = (state == CLEAR) && !scan_hit;
    assign clear_last = clear_wr && (clear_addr == LAST_ADDR);
    assign head       = fifo_mem[rd_ptr];

    always_comb begin
        state_next = state;
        mem_we     = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        case (state)
            IDLE:    if (clear_start) state_next = CLEAR;
            CLEAR:   if (clear_last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clear_wr) begin
            mem_we    = 1'b1;
            mem_waddr = clear_addr;
            mem_wdata = clear_col;
        end else if (pop) begin
            mem_we    = 1'b1;
            mem_waddr = head[17:3];
            mem_wdata = head[2:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            clear_addr  <= '0;
            clear_col   <= '0;
            clear_done  <= 1'b0;
            pix_written <= '0;
            pix_clipped <= '0;
        end else begin
            state      <= state_next;
            clear_done <= clear_last;
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
                clear_addr <= '0;
                clear_col  <= clear_colour;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                    2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                    default: fifo_count <= fifo_count;
                endcase
            end
            if (clear_wr) clear_addr <= clear_addr + 15'd1;
            if (pop && pix_written != SAT)  pix_written <= pix_written + 15'd1;
            if (clip && pix_clipped != SAT) pix_clipped <= pix_clipped + 15'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {pix_addr(in_x, in_y), in_colour};
    end

    // Framebuffer is never reset; a reset edge must not land a pending write.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) fb_mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_valid  <= 1'b0;
            scan_colour <= 3'b000;
        end else begin
            scan_valid  <= scan_req;
            scan_colour <= scan_hit ? fb_mem[pix_addr(scan_x, scan_y)] : 3'b000;
        end
    end

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Directed bench for pixel_fb_writer: scan reads checked against a framebuffer
// model through an expected-colour queue; counters and clear timing checked inline.
module tb_pixel_fb_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_x;
    logic [6:0]  in_y;
    logic [2:0]  in_colour;
    logic        in_plot;
    logic        in_ready;
    logic        scan_req;
    logic [7:0]  scan_x;
    logic [6:0]  scan_y;
    logic        scan_valid;
    logic [2:0]  scan_colour;
    logic        clear_start;
    logic [2:0]  clear_colour;
    logic        clear_busy;
    logic        clear_done;
    logic [14:0] pix_written;
    logic [14:0] pix_clipped;

    always #5 clk = ~clk;

    pixel_fb_writer dut (
        .clk(clk), .rst(rst),
        .in_x(in_x), .in_y(in_y), .in_colour(in_colour), .in_plot(in_plot),
        .in_ready(in_ready),
        .scan_req(scan_req), .scan_x(scan_x), .scan_y(scan_y),
        .scan_valid(scan_valid), .scan_colour(scan_colour),
        .clear_start(clear_start), .clear_colour(clear_colour),
        .clear_busy(clear_busy), .clear_done(clear_done),
        .pix_written(pix_written), .pix_clipped(pix_clipped)
    );

    int total = 0;
    int bad   = 0;
    logic [2:0] exp_q[$];
    logic [2:0] model [19200];
    logic [2:0] mon_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (scan_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL scan_unexpected observed=%0d expected=none", scan_colour);
            end else begin
                mon_e = exp_q.pop_front();
                check("scan_colour", {29'd0, scan_colour}, {29'd0, mon_e});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic plot(input int x, input int y, input int c);
        int n = 0;
        in_x = 8'(x); in_y = 7'(y); in_colour = 3'(c); in_plot = 1'b1;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("plot_ready", {31'd0, in_ready}, 1);
        tick();
        in_plot = 1'b0;
        if (x < 160 && y < 120) model[y*160 + x] = 3'(c);
    endtask

    task automatic scan(input int x, input int y);
        logic [2:0] e;
        if (x < 160 && y < 120) e = model[y*160 + x];
        else e = 3'b000;
        scan_x = 8'(x); scan_y = 7'(y); scan_req = 1'b1;
        exp_q.push_back(e);
        tick();
        scan_req = 1'b0;
    endtask

    initial begin
        int drops, k, n, acc, busy, stalls, dones, ready_bad, cyc, exp_pw;
        int px[6];
        int pc[6];
        px = '{10, 11, 12, 13, 14, 11};
        pc = '{1, 2, 3, 4, 5, 7};

        rst = 1'b1; in_x = '0; in_y = '0; in_colour = '0; in_plot = 1'b0;
        scan_req = 1'b0; scan_x = '0; scan_y = '0;
        clear_start = 1'b0; clear_colour = '0;
        repeat (3) tick();
        check("rst_scan_valid", {31'd0, scan_valid}, 0);
        check("rst_scan_colour", {29'd0, scan_colour}, 0);
        check("rst_clear_busy", {31'd0, clear_busy}, 0);
        check("rst_clear_done", {31'd0, clear_done}, 0);
        check("rst_pix_written", {17'd0, pix_written}, 0);
        check("rst_pix_clipped", {17'd0, pix_clipped}, 0);
        rst = 1'b0;
        tick();
        check("ready_after_rst", {31'd0, in_ready}, 1);

        // single plot then read back
        plot(5, 2, 5);
        repeat (3) tick();
        scan(5, 2);
        tick();
        check("single_written", {17'd0, pix_written}, 1);

        // full-screen fill, no scan traffic
        rst = 1'b1; tick(); rst = 1'b0; tick();
        drops = 0;
        for (int y = 0; y < 120; y++) begin
            for (int x = 0; x < 160; x++) begin
                in_x = 8'(x); in_y = 7'(y); in_colour = 3'(x % 8); in_plot = 1'b1;
                if (in_ready !== 1'b1) drops++;
                tick();
                model[y*160 + x] = 3'(x % 8);
            end
        end
        in_plot = 1'b0;
        repeat (4) tick();
        check("fill_ready_drops", drops, 0);
        check("fill_written", {17'd0, pix_written}, 19200);
        exp_pw = 19200;
        scan(0, 0);
        scan(159, 119);
        scan(13, 77);
        scan(200, 5);
        repeat (2) tick();

        // backpressure: continuous scan blocks the drain
        k = 0;
        for (int c = 0; c < 10; c++) begin
            scan_x = 8'd0; scan_y = 7'd0; scan_req = 1'b1;
            exp_q.push_back(model[0]);
            acc = 0;
            if (k < 6) begin
                in_x = 8'(px[k]); in_y = 7'd50; in_colour = 3'(pc[k]); in_plot = 1'b1;
                acc = (in_ready === 1'b1) ? 1 : 0;
            end else in_plot = 1'b0;
            tick();
            if (acc == 1) begin
                model[50*160 + px[k]] = 3'(pc[k]);
                k++;
            end
        end
        check("bp_accepted", k, 4);
        check("bp_ready_low", {31'd0, in_ready}, 0);
        check("bp_no_writes", {17'd0, pix_written}, exp_pw);
        scan_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            acc = 0;
            if (k < 6) begin
                in_x = 8'(px[k]); in_y = 7'd50; in_colour = 3'(pc[k]); in_plot = 1'b1;
                acc = (in_ready === 1'b1) ? 1 : 0;
            end else in_plot = 1'b0;
            tick();
            if (acc == 1) begin
                model[50*160 + px[k]] = 3'(pc[k]);
                k++;
            end
        end
        check("bp_drain4", {17'd0, pix_written}, exp_pw + 4);
        n = 0;
        while (k < 6 && n < 20) begin
            in_x = 8'(px[k]); in_y = 7'd50; in_colour = 3'(pc[k]); in_plot = 1'b1;
            acc = (in_ready === 1'b1) ? 1 : 0;
            tick();
            if (acc == 1) begin
                model[50*160 + px[k]] = 3'(pc[k]);
                k++;
            end
            n++;
        end
        in_plot = 1'b0;
        check("bp_all_accepted", k, 6);
        repeat (6) tick();
        exp_pw = exp_pw + 6;
        check("bp_written", {17'd0, pix_written}, exp_pw);
        for (int i = 10; i < 15; i++) scan(i, 50);
        repeat (2) tick();

        // clipping
        plot(160, 0, 1);
        plot(0, 120, 1);
        plot(255, 127, 1);
        repeat (3) tick();
        check("clip_count", {17'd0, pix_clipped}, 3);
        check("clip_written", {17'd0, pix_written}, exp_pw);
        check("clip_ready", {31'd0, in_ready}, 1);

        // clear with periodic scan stalls and an ignored restart
        clear_colour = 3'd2; clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        check("clr_busy_start", {31'd0, clear_busy}, 1);
        busy = 0; stalls = 0; dones = 0; ready_bad = 0; cyc = 0;
        while (clear_busy === 1'b1 && cyc < 40000) begin
            busy++;
            if (in_ready !== 1'b0) ready_bad++;
            if (cyc % 4 == 0) begin
                scan_x = 8'd159; scan_y = 7'd119; scan_req = 1'b1;
                exp_q.push_back(model[19199]);
                stalls++;
            end else scan_req = 1'b0;
            if (cyc == 100) begin
                clear_start = 1'b1; clear_colour = 3'd5;
            end else begin
                clear_start = 1'b0; clear_colour = 3'd2;
            end
            tick();
            if (clear_done === 1'b1) dones++;
            cyc++;
        end
        scan_req = 1'b0; clear_start = 1'b0;
        check("clr_busy_cycles", busy, 19200 + stalls);
        check("clr_done_pulses", dones, 1);
        check("clr_ready_low", ready_bad, 0);
        tick();
        check("clr_done_single", {31'd0, clear_done}, 0);
        check("clr_busy_end", {31'd0, clear_busy}, 0);
        check("clr_written", {17'd0, pix_written}, exp_pw);
        for (int i = 0; i < 19200; i++) model[i] = 3'd2;
        scan(0, 0);
        scan(80, 60);
        scan(159, 119);
        scan(11, 50);
        repeat (2) tick();

        // FIFO flush on clear_start, then reset mid-clear
        for (int i = 0; i < 3; i++) begin
            scan_x = 8'd0; scan_y = 7'd0; scan_req = 1'b1;
            exp_q.push_back(model[0]);
            in_x = 8'(20 + i); in_y = 7'd10; in_colour = 3'd6; in_plot = 1'b1;
            check("flush_ready", {31'd0, in_ready}, 1);
            tick();
        end
        scan_x = 8'd0; scan_y = 7'd0; scan_req = 1'b1;
        exp_q.push_back(model[0]);
        in_x = 8'd23; in_y = 7'd10; in_colour = 3'd6; in_plot = 1'b1;
        clear_colour = 3'd3; clear_start = 1'b1;
        tick();
        in_plot = 1'b0; clear_start = 1'b0; scan_req = 1'b0;
        check("flush_busy", {31'd0, clear_busy}, 1);
        check("flush_written", {17'd0, pix_written}, exp_pw);
        repeat (1000) tick();
        check("flush_written_mid", {17'd0, pix_written}, exp_pw);
        rst = 1'b1;
        tick();
        check("abort_busy", {31'd0, clear_busy}, 0);
        check("abort_done", {31'd0, clear_done}, 0);
        check("abort_written", {17'd0, pix_written}, 0);
        rst = 1'b0;
        tick();
        check("abort_done_after1", {31'd0, clear_done}, 0);
        tick();
        check("abort_done_after2", {31'd0, clear_done}, 0);
        for (int i = 0; i < 1000; i++) model[i] = 3'd3;
        scan(39, 6);
        scan(40, 6);
        scan(0, 0);
        scan(20, 10);
        scan(23, 10);
        repeat (2) tick();

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
